// File: rtl/ws2812_pkg.sv
// Shared constants and FSM state type for the WS2812 pixel feeder.
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    localparam int G_MSB = 23;
    localparam int R_MSB = 15;
    localparam int B_MSB = 7;

    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STREAM     = 2'd1,
        WAIT_LATCH = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/ws2812_refresh_timer.sv
// Free-running refresh counter; tick marks the last count of each period.
module ws2812_refresh_timer
    import ws2812_pkg::*;
#(
    parameter int REFRESH_CYCLES = 833333
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] count;

    // Count 0..REFRESH_CYCLES-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// Double-buffered pixel frame store streaming GRB pixels to the WS2812 encoder.
module ws2812_pixel_feeder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int AW             = 2,
    parameter int REFRESH_CYCLES = 833333
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               commit,
    output logic [PIXEL_W-1:0] px_data,
    output logic               px_valid,
    input  logic               px_ready,
    output logic               px_last,
    input  logic               latch_done,
    output logic               busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
    localparam logic [AW:0]   NUM_W    = (AW + 1)'(NUM_LEDS);

    logic [PIXEL_W-1:0] bank_a [NUM_LEDS];
    logic [PIXEL_W-1:0] bank_b [NUM_LEDS];

    feeder_state_t      state, state_next;
    logic               front_sel;
    logic               commit_pend, refresh_pend;
    logic               tick;
    logic [AW-1:0]      pix_idx, next_idx;
    logic               start, advance, finish, swap;
    logic [PIXEL_W-1:0] start_pixel, next_pixel;
    logic               wr_ok;

    ws2812_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and transfer-control decode.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (commit_pend || refresh_pend) begin
                    start      = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (px_valid && px_ready) begin
                    if (pix_idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = WAIT_LATCH;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WAIT_LATCH: begin
                if (latch_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel fetch: pixel 0 comes from the post-swap front bank.
    always_comb begin
        swap        = start && commit_pend;
        next_idx    = (pix_idx == LAST_IDX) ? '0 : pix_idx + AW'(1);
        start_pixel = (front_sel ^ commit_pend) ? bank_b[0] : bank_a[0];
        next_pixel  = front_sel ? bank_b[next_idx] : bank_a[next_idx];
        wr_ok       = wr_en && ({1'b0, wr_addr} < NUM_W);
    end

    // Host writes into the back bank; front_sel=0 means bank A is the front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_ok) begin
            if (front_sel) begin
                bank_a[wr_addr] <= wr_data;
            end else begin
                bank_b[wr_addr] <= wr_data;
            end
        end
    end

    // Request latching, buffer swap and output pixel register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend  <= 1'b0;
            refresh_pend <= 1'b0;
            front_sel    <= 1'b0;
            pix_idx      <= '0;
            px_data      <= '0;
            px_valid     <= 1'b0;
        end else begin
            // A request arriving in the decision cycle survives the clear.
            commit_pend  <= (commit_pend && !start) || commit;
            refresh_pend <= (refresh_pend && !start) || tick;
            if (swap) begin
                front_sel <= ~front_sel;
            end
            if (start) begin
                px_data  <= start_pixel;
                px_valid <= 1'b1;
                pix_idx  <= '0;
            end else if (advance) begin
                px_data <= next_pixel;
                pix_idx <= next_idx;
            end else if (finish) begin
                px_valid <= 1'b0;
            end
        end
    end

    assign px_last = px_valid && (pix_idx == LAST_IDX);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Scoreboard bench for the WS2812 pixel feeder: one instance with the default
// refresh period for commit-driven frames, one with a 20-cycle refresh period.
module tb_ws2812_pixel_feeder;
    import ws2812_pkg::*;

    localparam int AW = 2;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
    } px_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    // main instance signals
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          commit = 1'b0;
    logic [23:0]   px_data;
    logic          px_valid;
    logic          px_ready = 1'b1;
    logic          px_last;
    logic          latch_done = 1'b0;
    logic          busy;

    // fast-refresh instance signals
    logic          r_rst_n = 1'b0;
    logic          r_wr_en = 1'b0;
    logic [AW-1:0] r_wr_addr = '0;
    logic [23:0]   r_wr_data = '0;
    logic          r_commit = 1'b0;
    logic [23:0]   r_px_data;
    logic          r_px_valid;
    logic          r_px_ready = 1'b1;
    logic          r_px_last;
    logic          r_latch_done = 1'b0;
    logic          r_busy;
    logic          r_done = 1'b0;

    ws2812_pixel_feeder #(
        .NUM_LEDS(4), .AW(AW), .REFRESH_CYCLES(833333)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .px_data(px_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
        .latch_done(latch_done), .busy(busy)
    );

    ws2812_pixel_feeder #(
        .NUM_LEDS(4), .AW(AW), .REFRESH_CYCLES(20)
    ) dut_r (
        .clk(clk), .rst_n(r_rst_n), .wr_en(r_wr_en), .wr_addr(r_wr_addr),
        .wr_data(r_wr_data), .commit(r_commit), .px_data(r_px_data),
        .px_valid(r_px_valid), .px_ready(r_px_ready), .px_last(r_px_last),
        .latch_done(r_latch_done), .busy(r_busy)
    );

    px_t sb_q[$];
    px_t r_q[$];
    int  r_rise[$];
    int  r_lat_edge[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic px_t mk(input logic [23:0] d, input logic l);
        px_t p;
        p.data = d;
        p.last = l;
        return p;
    endfunction

    task automatic push_frame(input bit to_r, input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
        if (to_r) begin
            r_q.push_back(mk(p0, 1'b0)); r_q.push_back(mk(p1, 1'b0));
            r_q.push_back(mk(p2, 1'b0)); r_q.push_back(mk(p3, 1'b1));
        end else begin
            sb_q.push_back(mk(p0, 1'b0)); sb_q.push_back(mk(p1, 1'b0));
            sb_q.push_back(mk(p2, 1'b0)); sb_q.push_back(mk(p3, 1'b1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic r_wr(input logic [AW-1:0] a, input logic [23:0] d);
        r_wr_en = 1'b1; r_wr_addr = a; r_wr_data = d;
        step();
        r_wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic wr_frame(input logic [23:0] p0, input logic [23:0] p1,
                            input logic [23:0] p2, input logic [23:0] p3);
        wr(2'd0, p0); wr(2'd1, p1); wr(2'd2, p2); wr(2'd3, p3);
    endtask

    // Returns just after the edge on which the last pixel transferred.
    task automatic wait_frame_end(input string name);
        int n = 0;
        @(negedge clk);
        while (!(px_valid && px_ready && px_last) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s timeout waiting for last pixel, waited=%0d limit=300", name, n);
        end
        step();
    endtask

    task automatic pulse_latch(input string name);
        repeat (4) step();
        latch_done = 1'b1;
        step();
        latch_done = 1'b0;
        check({name, "_busy_after_latch"}, 32'(busy), 32'd0);
    endtask

    // Backpressure pattern 1,0,0 repeating when enabled.
    logic bp_en = 1'b0;
    int   bp_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            px_ready = (bp_cnt % 3 == 0);
            bp_cnt++;
        end else begin
            px_ready = 1'b1;
        end
    end

    // Main monitor: scoreboard pop on transfer, stability during stalls.
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data = '0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", 32'(px_valid), 32'd1);
                check("stall_data", 32'(px_data), 32'(prev_data));
                check("stall_last", 32'(px_last), 32'(prev_last));
            end
            if (px_valid && px_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_px actual=%h required=no transfer", px_data);
                end else begin
                    px_t e;
                    e = sb_q.pop_front();
                    check("px_data", 32'(px_data), 32'(e.data));
                    check("px_last", 32'(px_last), 32'(e.last));
                end
            end
            prev_stall = px_valid && !px_ready;
            prev_data  = px_data;
            prev_last  = px_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Fast-refresh monitor: scoreboard pop and px_valid rise times.
    logic r_prev_valid = 1'b0;
    always @(negedge clk) begin
        if (r_rst_n) begin
            if (r_px_valid && !r_prev_valid) r_rise.push_back(cyc);
            if (r_px_valid && r_px_ready) begin
                if (r_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected_px actual=%h required=no transfer", r_px_data);
                end else begin
                    px_t e;
                    e = r_q.pop_front();
                    check("r_px_data", 32'(r_px_data), 32'(e.data));
                    check("r_px_last", 32'(r_px_last), 32'(e.last));
                end
            end
            r_prev_valid = r_px_valid;
        end else begin
            r_prev_valid = 1'b0;
        end
    end

    // Encoder latch model for the fast instance; frame 3 latches late so a tick lands in WAIT_LATCH.
    int r_frames = 0;
    always @(negedge clk) begin
        if (r_rst_n && r_px_valid && r_px_ready && r_px_last) begin
            int d;
            d = (r_frames == 3) ? 25 : 5;
            r_frames++;
            repeat (d) @(posedge clk);
            #1;
            if (r_rst_n) begin
                r_latch_done = 1'b1;
                r_lat_edge.push_back(cyc + 1);
                @(posedge clk);
                #1;
                r_latch_done = 1'b0;
            end
        end
    end

    // Fast-refresh scenario: one commit, then tick-driven resends of the same bank.
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        r_rst_n = 1'b1;
        r_wr(2'd0, 24'h102030); r_wr(2'd1, 24'h405060);
        r_wr(2'd2, 24'h708090); r_wr(2'd3, 24'hA0B0C0);
        for (int f = 0; f < 5; f++) push_frame(1'b1, 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);
        r_commit = 1'b1;
        step();
        r_commit = 1'b0;
        repeat (3) step();
        // back-bank writes must never show up without a swap
        r_wr(2'd0, 24'hDEAD01); r_wr(2'd1, 24'hDEAD02);
        r_wr(2'd2, 24'hDEAD03); r_wr(2'd3, 24'hDEAD04);
        n = 0;
        while ((r_q.size() != 0 || r_rise.size() < 5) && n < 400) begin
            step();
            n++;
        end
        r_rst_n = 1'b0;
        check("r_queue_drained", 32'(r_q.size()), 32'd0);
        check("r_frame_count", 32'(r_rise.size()), 32'd5);
        if (r_rise.size() >= 5 && r_lat_edge.size() >= 4) begin
            check("r_tick_period_1", 32'(r_rise[2] - r_rise[1]), 32'd20);
            check("r_tick_period_2", 32'(r_rise[3] - r_rise[2]), 32'd20);
            check("r_tick_after_latch", 32'(r_rise[4]), 32'(r_lat_edge[3] + 1));
        end
        r_done = 1'b1;
    end

    // Main scenario sequence.
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_px_valid", 32'(px_valid), 32'd0);
        check("rst_px_data", 32'(px_data), 32'd0);
        check("rst_px_last", 32'(px_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // basic frame and launch latency
        wr_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        push_frame(1'b0, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        do_commit();
        check("s1_decide_valid", 32'(px_valid), 32'd0);
        check("s1_decide_busy", 32'(busy), 32'd0);
        step();
        check("s1_rise_valid", 32'(px_valid), 32'd1);
        check("s1_rise_busy", 32'(busy), 32'd1);
        check("s1_rise_data", 32'(px_data), 32'hFF0000);
        wait_frame_end("s1");
        check("s1_end_valid", 32'(px_valid), 32'd0);
        check("s1_end_last", 32'(px_last), 32'd0);
        check("s1_wait_busy", 32'(busy), 32'd1);
        pulse_latch("s1");

        // backpressure
        wr_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        push_frame(1'b0, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        bp_en = 1'b1;
        do_commit();
        wait_frame_end("s2");
        bp_en = 1'b0;
        pulse_latch("s2");

        // tearing: write during stream lands only in the next frame
        wr_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        push_frame(1'b0, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        do_commit();
        step();
        wr(2'd1, 24'hABCDEF);
        wait_frame_end("s3a");
        pulse_latch("s3a");
        push_frame(1'b0, 24'hFF0000, 24'hABCDEF, 24'h0000FF, 24'h123456);
        do_commit();
        wait_frame_end("s3b");
        pulse_latch("s3b");

        // repeated commits during a frame collapse into one extra frame
        wr_frame(24'h0A0B0C, 24'h0D0E0F, 24'h101112, 24'h131415);
        push_frame(1'b0, 24'h0A0B0C, 24'h0D0E0F, 24'h101112, 24'h131415);
        bp_en = 1'b1;
        do_commit();
        step();
        check("s5_stream_busy", 32'(busy), 32'd1);
        do_commit();
        step();
        do_commit();
        wr_frame(24'h212223, 24'h242526, 24'h272829, 24'h2A2B2C);
        push_frame(1'b0, 24'h212223, 24'h242526, 24'h272829, 24'h2A2B2C);
        wait_frame_end("s5a");
        pulse_latch("s5a");
        wait_frame_end("s5b");
        bp_en = 1'b0;
        pulse_latch("s5b");
        repeat (30) step();
        check("s5_no_third_frame", 32'(busy), 32'd0);
        check("s5_queue_empty", 32'(sb_q.size()), 32'd0);

        // asynchronous reset mid-frame
        wr_frame(24'h5A5A5A, 24'hA5A5A5, 24'h3C3C3C, 24'hC3C3C3);
        push_frame(1'b0, 24'h5A5A5A, 24'hA5A5A5, 24'h3C3C3C, 24'hC3C3C3);
        do_commit();
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(px_valid), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_last", 32'(px_last), 32'd0);
        check("s6_rst_data", 32'(px_data), 32'd0);
        check("s6_pixels_before_reset", 32'(sb_q.size()), 32'd2);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("s6_idle_busy", 32'(busy), 32'd0);
        check("s6_idle_valid", 32'(px_valid), 32'd0);
        push_frame(1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
        do_commit();
        wait_frame_end("s6");
        pulse_latch("s6");
        check("main_queue_empty", 32'(sb_q.size()), 32'd0);

        n = 0;
        while (!r_done && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (!r_done) begin
            failures++;
            $display("FAIL r_scenario timeout waited=%0d limit=1000", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_feeder.md
Name: ws2812_pixel_feeder

Overview:
- Upstream pixel source for the WS2812 bit encoder.
- Holds a double-buffered frame of NUM_LEDS 24-bit GRB pixels, written by the host.
- Streams the frame to the encoder over a valid/ready handshake, once per host commit or refresh tick, then waits for the encoder's reset/latch period to finish before it can start another frame.

Parameters:
- NUM_LEDS, 4: pixels per frame; must be ≥ 1.
- AW, 2: address width; NUM_LEDS ≤ 2**AW.
- REFRESH_CYCLES, 833333: clk cycles between automatic refreshes (60 Hz at 50 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  host pixel write strobe.
- wr_addr  in  AW  pixel index.
- wr_data  in  24  pixel, GRB, G in [23:16], MSB sent first.
- commit  in  1  one-cycle pulse: swap buffers and send the frame.
- px_data  out  24  pixel to the encoder.
- px_valid  out  1  px_data is valid.
- px_ready  in  1  encoder accepts the pixel.
- px_last  out  1  qualifies the final pixel of the frame.
- latch_done  in  1  pulse from the encoder: reset low time elapsed.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n low): px_valid=0, px_data=0, px_last=0, busy=0.
  - Internally: both banks=0, front_sel=0, pix_idx=0, timer=0, commit_pend=0, refresh_pend=0, state=IDLE.
  - Reset mid-frame aborts the stream immediately; no partial-frame recovery.
- Storage: banks A/B, NUM_LEDS x 24 each.
  - Host writes always target bank !front_sel, evaluated in the write cycle.
  - A wr_addr ≥ NUM_LEDS is ignored.
  - No copy-back on swap: the host rewrites the full frame before each commit.
- Refresh timer: free-running 0..REFRESH_CYCLES-1, wraps to 0.
  - tick is asserted when the count equals REFRESH_CYCLES-1; tick sets refresh_pend.
- commit sets commit_pend. A second commit while commit_pend is set has no effect; one pending request of each kind, maximum.
- FSM IDLE → STREAM when commit_pend or refresh_pend is set:
  - On that edge: if commit_pend, toggle front_sel (swap).
  - Clear both pend flags.
  - Load px_data = front[0] from the post-swap front bank.
  - Set px_valid=1 and pix_idx=0.
  - px_valid rises on the cycle after the decision cycle (1-cycle latency).
- A commit or tick arriving in the same cycle as the IDLE decision is captured and served next frame.
- A write in the swap cycle lands in the old back bank, i.e. the new front, and is not guaranteed visible in pixel 0.
- STREAM handshake:
  - While px_valid && !px_ready, hold px_data, px_valid and px_last stable.
  - On px_valid && px_ready with pix_idx < NUM_LEDS-1: increment pix_idx and load the next pixel; px_valid stays high with no bubble.
  - px_last = (pix_idx == NUM_LEDS-1) && px_valid.
  - On transfer of the last pixel: px_valid=0, px_last=0, go to WAIT_LATCH.
- WAIT_LATCH → IDLE on latch_done. latch_done in any other state is ignored.
- busy=1 in STREAM and WAIT_LATCH.
- Ticks and commits during STREAM/WAIT_LATCH are latched, never dropped. Host writes during a frame never alter the streamed frame, since the streamed frame always comes from the front bank.
- NUM_LEDS=1: the first pixel has px_last=1.

Decomposition:
- Package ws2812_pkg:
  - PIXEL_W=24.
  - GRB field offsets (G_MSB=23, R_MSB=15, B_MSB=7).
  - Feeder FSM state encoding (IDLE, STREAM, WAIT_LATCH).
  - CLK_HZ=50_000_000.
- One sub-module, ws2812_refresh_timer: parameter REFRESH_CYCLES; clk, rst_n in; tick out.

Test Plan:
1. Reset, then write A: addr0..3 = 0xFF0000, 0x00FF00, 0x0000FF, 0x123456; pulse commit; px_ready=1 → 4 consecutive transfers with exactly those values, px_last only on 0x123456, busy=1, px_valid rises 1 cycle after the IDLE decision.
2. Backpressure: px_ready toggles 1,0,0,1,... → px_data, px_valid and px_last are stable during every stall; the sequence is identical to scenario 1.
3. Tearing check: during STREAM, write addr1=0xABCDEF → the current frame still shows 0x00FF00; after a second commit, the next frame shows 0xABCDEF.
4. REFRESH_CYCLES=20, no commit, latch_done pulsed 5 cycles after last → a frame starts every 20 cycles resending the same bank with no swap; a tick arriving in WAIT_LATCH starts the frame on the cycle after latch_done.
5. Two commits during STREAM plus a tick → exactly one extra frame, exactly one swap.
6. rst_n low mid-frame (after pixel 1) → px_valid=0 and busy=0 asynchronously, banks=0; after release, with no commit/tick, the FSM stays IDLE.
